eth_backoff_ctrl: RTL and testbench
===================================

ETH_BACKOFF_CTRL -- requirements
Module: eth_backoff_ctrl

Interface
REQ-001 SHALL have parameter Tp, default 1, register assignment delay in time units.
REQ-002 SHALL have parameter JamNib, default 8, jam length in MTxClk (nibble) cycles.
REQ-003 SHALL have parameter IfgNib, default 24, defer (interframe gap) length in nibble cycles.
REQ-004 SHALL have port MTxClk input 1, transmit nibble clock; all state on rising edge.
REQ-005 SHALL have port Reset input 1, asynchronous, active-high.
REQ-006 SHALL have port StartTx input 1, request to begin a new frame.
REQ-007 SHALL have port TxDone input 1, last nibble of frame sent without collision.
REQ-008 SHALL have port Collision input 1, synchronous collision indication from PHY.
REQ-009 SHALL have port MaxRet input 4, maximum retry count allowed.
REQ-010 SHALL have port NoBckof input 1, skip backoff and go straight to defer.
REQ-011 SHALL have port RandomEq0 input 1, latched backoff random number equals 0.
REQ-012 SHALL have port RandomEqByteCnt input 1, slot count equals random number at slot end.
REQ-013 SHALL have ports StateIdle, StateData, StateJam, StateBackOff, StateDefer, output 1 each, one-hot state.
REQ-014 SHALL have port StateJam_q output 1, StateJam delayed one cycle.
REQ-015 SHALL have port RetryCnt output 4, collisions for the current frame.
REQ-016 SHALL have port NibCnt output 16, nibbles elapsed in current state.
REQ-017 SHALL have port ByteCnt output 10, backoff slot counter.
REQ-018 SHALL have ports TxDonePulse, TxAbort, TxRetry output 1 each, single-cycle event pulses.

Function
REQ-019 SHALL implement states IDLE, DATA, JAM, BACKOFF, DEFER; exactly one State* output high at all times.
REQ-020 IDLE: StartTx -> DATA next cycle, RetryCnt cleared to 0; StartTx ignored in all other states.
REQ-021 DATA: Collision -> JAM; else TxDone -> IDLE with TxDonePulse=1 and RetryCnt cleared; Collision and TxDone same cycle -> JAM (Collision wins).
REQ-022 On DATA->JAM transition RetryCnt SHALL increment by 1, saturating at 15.
REQ-023 JAM SHALL last exactly JamNib cycles (NibCnt 0..JamNib-1); Collision ignored in JAM.
REQ-024 Jam end (NibCnt==JamNib-1): RetryCnt>MaxRet -> IDLE, TxAbort=1, RetryCnt cleared; else NoBckof|RandomEq0 -> DEFER; else -> BACKOFF; TxRetry=1 on both non-abort exits.
REQ-025 BACKOFF: ByteCnt=0 on entry, increments by 1 when NibCnt[6:0]==7'h7F and RandomEqByteCnt=0; RandomEqByteCnt=1 -> DEFER; ByteCnt wraps at 10 bits.
REQ-026 DEFER SHALL last exactly IfgNib cycles then -> DATA (retransmission); Collision ignored in DEFER.
REQ-027 NibCnt SHALL clear to 0 on every state change, else increment each cycle in DATA/JAM/BACKOFF/DEFER, saturate at 16'hFFFF, hold 0 in IDLE.
REQ-028 ByteCnt SHALL hold 0 outside BACKOFF.
REQ-029 StateJam_q SHALL be a plain register of StateJam (so StateJam&StateJam_q is true from second jam cycle).
REQ-030 Pulses SHALL be registered, asserted in the first cycle of the destination state.

Reset
REQ-031 Reset high SHALL asynchronously force IDLE: StateIdle=1, other State*=0, StateJam_q=0, RetryCnt=0, NibCnt=0, ByteCnt=0, all pulses 0.
REQ-032 Reset mid-frame (any state) SHALL abandon the frame without TxAbort or TxDonePulse.

Verification
REQ-033 StartTx, TxDone after 20 cycles -> DATA for 20 cycles, IDLE, TxDonePulse once, RetryCnt=0.
REQ-034 Collision in DATA, RandomEq0=1, MaxRet=15 -> JAM 8 cycles, RetryCnt=1, TxRetry, DEFER 24 cycles, DATA.
REQ-035 Collision, RandomEq0=0, RandomEqByteCnt driven true when ByteCnt==2 & NibCnt[6:0]==127 -> BACKOFF 384 cycles, then DEFER.
REQ-036 MaxRet=2, three successive collisions -> third jam end goes IDLE, TxAbort=1, RetryCnt=0.
REQ-037 Collision and TxDone same cycle in DATA -> JAM, no TxDonePulse; Collision during JAM/DEFER ignored.
REQ-038 Reset asserted mid-BACKOFF -> immediate IDLE, counters 0, no pulses.

Source files
------------

// File: rtl/eth_backoff_ctrl.sv
// Ethernet MAC transmit retry controller: sequences a frame through data,
// jam, backoff and defer, counting collisions and aborting past MaxRet.
module eth_backoff_ctrl #(
  parameter int          Tp     = 1,
  parameter int unsigned JamNib = 8,
  parameter int unsigned IfgNib = 24
) (
  input  logic        MTxClk,
  input  logic        Reset,
  input  logic        StartTx,
  input  logic        TxDone,
  input  logic        Collision,
  input  logic [3:0]  MaxRet,
  input  logic        NoBckof,
  input  logic        RandomEq0,
  input  logic        RandomEqByteCnt,
  output logic        StateIdle,
  output logic        StateData,
  output logic        StateJam,
  output logic        StateBackOff,
  output logic        StateDefer,
  output logic        StateJam_q,
  output logic [3:0]  RetryCnt,
  output logic [15:0] NibCnt,
  output logic [9:0]  ByteCnt,
  output logic        TxDonePulse,
  output logic        TxAbort,
  output logic        TxRetry
);

  // One-hot encoding so the State* outputs come straight off the register.
  typedef enum logic [4:0] {
    StIdle    = 5'b00001,
    StData    = 5'b00010,
    StJam     = 5'b00100,
    StBackOff = 5'b01000,
    StDefer   = 5'b10000
  } state_e;

  localparam logic [15:0] JamLast = 16'(JamNib - 1);
  localparam logic [15:0] IfgLast = 16'(IfgNib - 1);

  // Tp only delayed register updates in the legacy behavioural model; it has
  // no synthesizable meaning and is kept so existing instantiations still bind.
  if (Tp < 0) begin : g_tp_unused
  end

  state_e      state_q;
  logic [15:0] nib_inc;
  logic [3:0]  retry_inc;

  assign nib_inc   = (NibCnt == 16'hFFFF) ? NibCnt : NibCnt + 16'd1;
  assign retry_inc = (RetryCnt == 4'hF) ? RetryCnt : RetryCnt + 4'd1;

  assign StateIdle    = state_q[0];
  assign StateData    = state_q[1];
  assign StateJam     = state_q[2];
  assign StateBackOff = state_q[3];
  assign StateDefer   = state_q[4];

  // State machine with its counters and event pulses; any transition clears NibCnt.
  always_ff @(posedge MTxClk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      StateJam_q  <= 1'b0;
      RetryCnt    <= 4'd0;
      NibCnt      <= 16'd0;
      ByteCnt     <= 10'd0;
      TxDonePulse <= 1'b0;
      TxAbort     <= 1'b0;
      TxRetry     <= 1'b0;
    end else begin
      StateJam_q  <= state_q[2];
      TxDonePulse <= 1'b0;
      TxAbort     <= 1'b0;
      TxRetry     <= 1'b0;
      NibCnt      <= nib_inc;
      ByteCnt     <= 10'd0;
      unique case (state_q)
        StIdle: begin
          NibCnt <= 16'd0;
          if (StartTx) begin
            state_q  <= StData;
            RetryCnt <= 4'd0;
          end
        end
        StData: begin
          // Collision takes priority over a simultaneous TxDone.
          if (Collision) begin
            state_q  <= StJam;
            NibCnt   <= 16'd0;
            RetryCnt <= retry_inc;
          end else if (TxDone) begin
            state_q     <= StIdle;
            NibCnt      <= 16'd0;
            RetryCnt    <= 4'd0;
            TxDonePulse <= 1'b1;
          end
        end
        StJam: begin
          if (NibCnt == JamLast) begin
            NibCnt <= 16'd0;
            if (RetryCnt > MaxRet) begin
              state_q  <= StIdle;
              RetryCnt <= 4'd0;
              TxAbort  <= 1'b1;
            end else begin
              TxRetry <= 1'b1;
              state_q <= (NoBckof || RandomEq0) ? StDefer : StBackOff;
            end
          end
        end
        StBackOff: begin
          if (RandomEqByteCnt) begin
            state_q <= StDefer;
            NibCnt  <= 16'd0;
          end else if (NibCnt[6:0] == 7'h7F) begin
            ByteCnt <= ByteCnt + 10'd1;
          end else begin
            ByteCnt <= ByteCnt;
          end
        end
        StDefer: begin
          if (NibCnt == IfgLast) begin
            state_q <= StData;
            NibCnt  <= 16'd0;
          end
        end
        default: begin
          state_q <= StIdle;
          NibCnt  <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_backoff_ctrl.sv
// Self-checking bench for eth_backoff_ctrl: table vectors, directed corner
// sequences and random stimulus against a cycle-level behavioural model.
module tb_eth_backoff_ctrl;

  localparam int JamNib = 8;
  localparam int IfgNib = 24;

  logic        MTxClk = 1'b0;
  logic        Reset, StartTx, TxDone, Collision, NoBckof, RandomEq0, RandomEqByteCnt;
  logic [3:0]  MaxRet;
  logic        StateIdle, StateData, StateJam, StateBackOff, StateDefer, StateJam_q;
  logic [3:0]  RetryCnt;
  logic [15:0] NibCnt;
  logic [9:0]  ByteCnt;
  logic        TxDonePulse, TxAbort, TxRetry;

  int total = 0;
  int bad   = 0;

  always #5 MTxClk = ~MTxClk;

  eth_backoff_ctrl #(.Tp(1), .JamNib(JamNib), .IfgNib(IfgNib)) dut (
    .MTxClk(MTxClk), .Reset(Reset), .StartTx(StartTx), .TxDone(TxDone),
    .Collision(Collision), .MaxRet(MaxRet), .NoBckof(NoBckof), .RandomEq0(RandomEq0),
    .RandomEqByteCnt(RandomEqByteCnt), .StateIdle(StateIdle), .StateData(StateData),
    .StateJam(StateJam), .StateBackOff(StateBackOff), .StateDefer(StateDefer),
    .StateJam_q(StateJam_q), .RetryCnt(RetryCnt), .NibCnt(NibCnt), .ByteCnt(ByteCnt),
    .TxDonePulse(TxDonePulse), .TxAbort(TxAbort), .TxRetry(TxRetry)
  );

  // Behavioural model: mode 0 idle, 1 data, 2 jam, 3 backoff, 4 defer.
  int m_mode, m_time, m_slot, m_retries;
  bit m_done, m_abort, m_retry, m_jamq;

  localparam logic [38:0] IdleVec = {5'b00001, 34'd0};

  function automatic logic [38:0] dut_vec();
    return {StateDefer, StateBackOff, StateJam, StateData, StateIdle, StateJam_q,
            RetryCnt, NibCnt, ByteCnt, TxDonePulse, TxAbort, TxRetry};
  endfunction

  function automatic logic [38:0] model_vec();
    return {5'(1 << m_mode), m_jamq, 4'(m_retries), 16'(m_time), 10'(m_slot),
            m_done, m_abort, m_retry};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_time = 0; m_slot = 0; m_retries = 0;
    m_done = 0; m_abort = 0; m_retry = 0; m_jamq = 0;
  endtask

  task automatic model_step();
    int nm;
    nm = m_mode;
    m_jamq = (m_mode == 2);
    m_done = 0; m_abort = 0; m_retry = 0;
    case (m_mode)
      0: if (StartTx) begin nm = 1; m_retries = 0; end
      1: begin
        if (Collision) begin
          nm = 2;
          if (m_retries < 15) m_retries++;
        end else if (TxDone) begin
          nm = 0; m_done = 1; m_retries = 0;
        end
      end
      2: begin
        if (m_time == JamNib - 1) begin
          if (m_retries > int'(MaxRet)) begin
            nm = 0; m_abort = 1; m_retries = 0;
          end else begin
            m_retry = 1;
            nm = (NoBckof || RandomEq0) ? 4 : 3;
          end
        end
      end
      3: begin
        if (RandomEqByteCnt) nm = 4;
        else if (m_time % 128 == 127) m_slot = (m_slot + 1) % 1024;
      end
      4: if (m_time == IfgNib - 1) nm = 1;
      default: ;
    endcase
    if (nm != m_mode) m_time = 0;
    else if (m_mode != 0 && m_time < 65535) m_time++;
    if (nm != 3) m_slot = 0;
    m_mode = nm;
  endtask

  // One clock: model advances on the edge, DUT compared on the falling edge.
  task automatic step();
    @(posedge MTxClk);
    model_step();
    @(negedge MTxClk);
    check("model", dut_vec(), model_vec());
  endtask

  task automatic clear_inputs();
    StartTx = 0; TxDone = 0; Collision = 0; NoBckof = 0;
    RandomEq0 = 0; RandomEqByteCnt = 0;
  endtask

  typedef struct {
    logic        start, done, coll, eq0;
    logic [4:0]  st;      // {Defer, BackOff, Jam, Data, Idle}
    logic [3:0]  retry;
    logic [15:0] nib;
    logic [2:0]  pulse;   // {TxDonePulse, TxAbort, TxRetry}
  } vec_t;

  vec_t tbl[13];

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt, pulses;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b00001, 4'd0, 16'd0, 3'b000};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 5'b00010, 4'd0, 16'd0, 3'b000};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b00010, 4'd0, 16'd1, 3'b000};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b00010, 4'd0, 16'd2, 3'b000};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 5'b00100, 4'd1, 16'd0, 3'b000};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 5'b00100, 4'd1, 16'd1, 3'b000};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 5'b00100, 4'd1, 16'd2, 3'b000};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b00100, 4'd1, 16'd3, 3'b000};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b00100, 4'd1, 16'd4, 3'b000};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b00100, 4'd1, 16'd5, 3'b000};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b00100, 4'd1, 16'd6, 3'b000};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b00100, 4'd1, 16'd7, 3'b000};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b10000, 4'd1, 16'd0, 3'b001};

    clear_inputs();
    MaxRet = 4'd15;
    Reset  = 1'b1;
    model_reset();
    @(negedge MTxClk);
    @(negedge MTxClk);
    check("reset_state", dut_vec(), IdleVec);
    Reset = 1'b0;

    // Table: start, collision+txdone together, ignored collision/start in jam.
    for (int i = 0; i < 13; i++) begin
      StartTx = tbl[i].start; TxDone = tbl[i].done;
      Collision = tbl[i].coll; RandomEq0 = tbl[i].eq0;
      step();
      check($sformatf("vec%0d", i),
            {StateDefer, StateBackOff, StateJam, StateData, StateIdle, RetryCnt, NibCnt,
             TxDonePulse, TxAbort, TxRetry},
            {tbl[i].st, tbl[i].retry, tbl[i].nib, tbl[i].pulse});
    end
    clear_inputs();

    // Defer length with collision held high (must be ignored).
    cnt = 0;
    Collision = 1;
    for (int i = 0; i < 100 && StateDefer; i++) begin
      cnt++;
      step();
    end
    Collision = 0;
    check("defer_len", 64'(cnt), 64'(IfgNib));
    check("defer_to_data", {StateData, RetryCnt}, {1'b1, 4'd1});

    TxDone = 1; step(); TxDone = 0;
    check("retx_done", {StateIdle, TxDonePulse, RetryCnt}, {1'b1, 1'b1, 4'd0});

    // Plain frame: 20 data cycles, one done pulse.
    StartTx = 1; step(); StartTx = 0;
    cnt = 0;
    for (int i = 0; i < 19; i++) begin
      if (StateData) cnt++;
      step();
    end
    TxDone = 1;
    if (StateData) cnt++;
    step();
    TxDone = 0;
    check("data_len", 64'(cnt), 64'd20);
    check("frame_done", {StateIdle, RetryCnt}, {1'b1, 4'd0});
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      if (TxDonePulse) pulses++;
      step();
    end
    check("done_pulse_once", 64'(pulses), 64'd1);

    // Backoff until slot 2 ends: 3 slots of 128 nibbles.
    StartTx = 1; step(); StartTx = 0;
    Collision = 1; step(); Collision = 0;
    for (int i = 0; i < 20 && !StateBackOff; i++) step();
    check("enter_backoff", StateBackOff, 1'b1);
    cnt = 0;
    for (int i = 0; i < 1000 && StateBackOff; i++) begin
      cnt++;
      RandomEqByteCnt = (m_slot == 2 && m_time % 128 == 127);
      step();
    end
    RandomEqByteCnt = 0;
    check("backoff_len", 64'(cnt), 64'd384);
    check("backoff_to_defer", {StateDefer, ByteCnt}, {1'b1, 10'd0});
    for (int i = 0; i < 40 && StateDefer; i++) step();
    TxDone = 1; step(); TxDone = 0;
    check("backoff_frame_done", StateIdle, 1'b1);

    // Retry limit: third collision with MaxRet=2 aborts.
    MaxRet = 4'd2; RandomEq0 = 1;
    StartTx = 1; step(); StartTx = 0;
    for (int k = 1; k <= 3; k++) begin
      Collision = 1; step(); Collision = 0;
      check($sformatf("retry_cnt%0d", k), RetryCnt, 64'(k));
      for (int i = 0; i < 20 && StateJam; i++) step();
      if (k < 3) begin
        check("retry_exit", {StateDefer, TxRetry, TxAbort}, 3'b110);
        for (int i = 0; i < 40 && StateDefer; i++) step();
        check("back_to_data", StateData, 1'b1);
      end else begin
        check("abort_exit", {StateIdle, TxAbort, TxRetry, RetryCnt}, {3'b110, 4'd0});
      end
    end
    step();
    check("abort_single", TxAbort, 1'b0);
    RandomEq0 = 0; MaxRet = 4'd15;

    // Asynchronous reset in the middle of backoff.
    StartTx = 1; step(); StartTx = 0;
    Collision = 1; step(); Collision = 0;
    for (int i = 0; i < 20 && !StateBackOff; i++) step();
    for (int i = 0; i < 150; i++) step();
    check("mid_backoff", {StateBackOff, ByteCnt}, {1'b1, 10'd1});
    #2 Reset = 1;
    #1 check("async_reset", dut_vec(), IdleVec);
    @(negedge MTxClk);
    check("reset_hold", dut_vec(), IdleVec);
    model_reset();
    Reset = 0;
    step();

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if (i % 100 == 0) MaxRet = 4'($urandom_range(0, 15));
      StartTx   = ($urandom % 4) == 0;
      TxDone    = ($urandom % 16) == 0;
      Collision = ($urandom % 12) == 0;
      NoBckof   = ($urandom % 8) == 0;
      RandomEq0 = ($urandom % 3) == 0;
      RandomEqByteCnt = (m_mode == 3) ? (($urandom % 200) == 0) : 1'($urandom % 2);
      step();
    end
    clear_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
